// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the program counter, issues single-outstanding
// instruction-memory reads and queues returned words (with their PC) for decode.
module instruction_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_value,
  output logic              pc_enable,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_in,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready
);

  // state | meaning
  // IDLE  | no request pending, waiting for FIFO space
  // REQ   | imem_req asserted at pc_value until granted
  // WAIT  | one request in flight, waiting for imem_rvalid
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  state_t            state, state_nxt;
  logic              outstanding, outstanding_nxt;
  logic              drop, drop_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;

  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_after;
  logic [CW:0]       occupancy;
  logic              resp, push, pop, space;

  assign resp        = imem_rvalid & outstanding;
  assign push        = resp & ~drop & ~redirect_valid;
  assign pop         = ir_valid & ir_ready;
  assign count_after = count + CW'(push) - CW'(pop);
  assign space       = count_after < CW'(DEPTH);
  assign occupancy   = {1'b0, count} + {{CW{1'b0}}, outstanding};

  assign ir_valid = (count != '0);
  assign ir_data  = fifo_data[rd_ptr];
  assign ir_pc    = fifo_pc[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      fetch_pc    <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      fetch_pc    <= fetch_pc_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    outstanding_nxt = outstanding;
    drop_nxt        = drop;
    fetch_pc_nxt    = fetch_pc;
    imem_req        = 1'b0;
    imem_addr       = '0;
    pc_enable       = 1'b0;
    pc_load         = 1'b0;
    pc_in           = '0;

    case (state)
      IDLE: begin
        if (!redirect_valid && occupancy < (CW+1)'(DEPTH))
          state_nxt = REQ;
      end
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_value;
        if (imem_gnt) begin
          pc_enable       = 1'b1;
          fetch_pc_nxt    = pc_value;
          outstanding_nxt = 1'b1;
          state_nxt       = WAIT;
        end
      end
      WAIT: begin
        if (resp) begin
          outstanding_nxt = 1'b0;
          drop_nxt        = 1'b0;
          state_nxt       = space ? REQ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides the increment; a request still in flight is marked for discard.
    if (redirect_valid) begin
      pc_enable = 1'b1;
      pc_load   = 1'b1;
      pc_in     = redirect_addr;
      if (outstanding_nxt) begin
        state_nxt = WAIT;
        drop_nxt  = 1'b1;
      end else begin
        state_nxt = IDLE;
        drop_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]   <= fetch_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_after;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a cycle table for the basic fetch cadence, directed
// redirect/stall/wrap/reset sequences, and a randomized run against a stream-order model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_reg;
  logic        pc_enable, pc_load;
  logic [15:0] pc_in;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [15:0] imem_rdata;
  logic        ir_valid;
  logic [15:0] ir_data, ir_pc;
  logic        ir_ready;

  instruction_fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .pc_value(pc_reg),
    .pc_enable(pc_enable), .pc_load(pc_load), .pc_in(pc_in),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, rv, rdy;
    logic [15:0] rdata;
    logic        e_req, e_en, e_load, e_irv;
    logic [15:0] e_addr, e_irpc, e_irdata;
  } vec_t;
  vec_t tbl [12];

  int vectors = 0, miscompares = 0;
  logic cap_req, cap_gnt, cap_rv, cap_en, cap_load;
  logic [15:0] cap_addr, cap_in;
  logic auto_mem = 1'b0, rand_mode = 1'b0, chk_en = 1'b0;
  int gnt_pct = 100, lat_min = 1, lat_max = 1, wait_cnt = 0, pops = 0;
  logic pend = 1'b0;
  logic [15:0] pend_addr, exp_pc;
  logic [15:0] gnt_q [$];
  logic found;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic sample();
    cap_req = imem_req; cap_gnt = imem_gnt; cap_rv = imem_rvalid;
    cap_en = pc_enable; cap_load = pc_load; cap_addr = imem_addr; cap_in = pc_in;
  endtask

  // Stream model: decode must see consecutive addresses, restarting at each redirect target.
  task automatic model_check();
    if (imem_req) chk("addr_is_pc", 32'(imem_addr), 32'(pc_reg));
    chk("pc_enable", 32'(pc_enable), 32'(redirect_valid | (imem_req & imem_gnt)));
    chk("pc_load", 32'(pc_load), 32'(redirect_valid));
    if (redirect_valid) chk("pc_in", 32'(pc_in), 32'(redirect_addr));
    if (pend) chk("single_outstanding", 32'(imem_req), 32'(0));
    if (redirect_valid) exp_pc = redirect_addr;
    else if (ir_valid && ir_ready) begin
      chk("stream_pc", 32'(ir_pc), 32'(exp_pc));
      chk("stream_data", 32'(ir_data), 32'(exp_pc ^ 16'hA5A5));
      exp_pc = exp_pc + 16'd1;
      pops++;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    sample();
    if (chk_en) model_check();
  endtask

  // Advance one edge: program_counter model, memory model, random stimulus.
  task automatic adv();
    @(posedge clk); #1;
    if (cap_en) pc_reg = cap_load ? cap_in : pc_reg + 16'd1;
    if (cap_req && cap_gnt) begin
      gnt_q.push_back(cap_addr);
      pend = 1'b1; pend_addr = cap_addr;
      wait_cnt = int'($urandom_range(lat_min, lat_max)) - 1;
    end else if (pend && cap_rv) pend = 1'b0;
    if (auto_mem) begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
      if (pend) begin
        if (wait_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend_addr ^ 16'hA5A5;
        end else wait_cnt--;
      end
      imem_gnt = int'($urandom_range(0, 99)) < gnt_pct;
    end
    if (rand_mode) begin
      redirect_valid = int'($urandom_range(0, 99)) < 4;
      redirect_addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      ir_ready       = int'($urandom_range(0, 99)) < 60;
    end
  endtask

  task automatic do_reset(input logic [15:0] start_pc);
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_addr = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; ir_ready = 1'b0; pend = 1'b0; gnt_q.delete();
    cap_req = 1'b0; cap_gnt = 1'b0; cap_rv = 1'b0; cap_en = 1'b0; cap_load = 1'b0;
    pc_reg = start_pc;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic expect_pops(input int n, input logic [15:0] start, input int maxcyc);
    int k = 0;
    for (int c = 0; c < maxcyc && k < n; c++) begin
      at_neg();
      if (ir_valid && ir_ready && !redirect_valid) begin
        chk("pop_pc", 32'(ir_pc), 32'(16'(start + 16'(k))));
        chk("pop_data", 32'(ir_data), 32'(16'(start + 16'(k)) ^ 16'hA5A5));
        k++;
      end
      adv();
    end
    if (k < n) chk("pop_timeout", 32'(k), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: gnt tied high, 1-cycle memory, decode always ready, PC from 0.
    for (int i = 0; i < 12; i++) begin
      int k;
      tbl[i].gnt = 1'b1; tbl[i].rdy = 1'b1; tbl[i].rv = 1'b0; tbl[i].rdata = '0;
      tbl[i].e_req = 1'b0; tbl[i].e_en = 1'b0; tbl[i].e_load = 1'b0; tbl[i].e_irv = 1'b0;
      tbl[i].e_addr = '0; tbl[i].e_irpc = '0; tbl[i].e_irdata = '0;
      if (i == 0) begin
        tbl[i].rv = 1'b1; tbl[i].rdata = 16'hFFFF;
      end else if (i % 2 == 1) begin
        k = (i - 1) / 2;
        tbl[i].e_req = 1'b1; tbl[i].e_addr = 16'(k); tbl[i].e_en = 1'b1;
        if (i >= 3) begin
          tbl[i].e_irv = 1'b1; tbl[i].e_irpc = 16'(k - 1);
          tbl[i].e_irdata = 16'(k - 1) ^ 16'hA5A5;
        end
      end else begin
        k = (i - 2) / 2;
        tbl[i].rv = 1'b1; tbl[i].rdata = 16'(k) ^ 16'hA5A5;
      end
    end

    do_reset(16'h0000);
    for (int i = 0; i < 12; i++) begin
      imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv;
      imem_rdata = tbl[i].rdata; ir_ready = tbl[i].rdy;
      at_neg();
      chk($sformatf("t%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req || i == 0) chk($sformatf("t%0d_addr", i), 32'(imem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("t%0d_pc_en", i), 32'(pc_enable), 32'(tbl[i].e_en));
      chk($sformatf("t%0d_pc_load", i), 32'(pc_load), 32'(tbl[i].e_load));
      if (i == 0) chk("t0_pc_in", 32'(pc_in), 32'(0));
      chk($sformatf("t%0d_ir_valid", i), 32'(ir_valid), 32'(tbl[i].e_irv));
      if (tbl[i].e_irv || i == 0) begin
        chk($sformatf("t%0d_ir_pc", i), 32'(ir_pc), 32'(tbl[i].e_irpc));
        chk($sformatf("t%0d_ir_data", i), 32'(ir_data), 32'(tbl[i].e_irdata));
      end
      adv();
    end

    // Decode stalled: exactly two grants, then fetching resumes at address 2.
    do_reset(16'h0000);
    auto_mem = 1'b1; gnt_pct = 100; lat_min = 1; lat_max = 1;
    begin
      int late_reqs = 0;
      for (int c = 0; c < 16; c++) begin
        at_neg();
        if (c >= 10 && imem_req) late_reqs++;
        adv();
      end
      chk("stall_grants", 32'(gnt_q.size()), 32'(2));
      chk("stall_no_req", 32'(late_reqs), 32'(0));
    end
    at_neg();
    chk("stall_ir_valid", 32'(ir_valid), 32'(1));
    chk("stall_ir_pc", 32'(ir_pc), 32'(0));
    adv();
    ir_ready = 1'b1;
    expect_pops(6, 16'h0000, 60);
    chk("resume_addr", 32'((gnt_q.size() > 2) ? gnt_q[2] : 16'hDEAD), 32'(2));

    // Redirect while waiting on addr 5 (late response must be dropped).
    do_reset(16'h0004);
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      at_neg();
      if (imem_req && imem_gnt && imem_addr == 16'h0005) found = 1'b1;
      adv();
      if (found) break;
    end
    chk("grant_addr5", 32'(found), 32'(1));
    redirect_valid = 1'b1; redirect_addr = 16'h0100;
    at_neg();
    chk("redir_pc_en", 32'(pc_enable), 32'(1));
    chk("redir_pc_load", 32'(pc_load), 32'(1));
    chk("redir_pc_in", 32'(pc_in), 32'(16'h0100));
    chk("redir_pre_valid", 32'(ir_valid), 32'(1));
    adv();
    redirect_valid = 1'b0;
    at_neg();
    chk("redir_flushed", 32'(ir_valid), 32'(0));
    adv();
    ir_ready = 1'b1;
    expect_pops(1, 16'h0100, 20);

    // Redirect with a full FIFO.
    do_reset(16'h0020);
    lat_min = 1; lat_max = 1;
    repeat (10) begin at_neg(); adv(); end
    at_neg();
    chk("full_ir_valid", 32'(ir_valid), 32'(1));
    chk("full_ir_pc", 32'(ir_pc), 32'(16'h0020));
    adv();
    redirect_valid = 1'b1; redirect_addr = 16'h0200;
    at_neg();
    chk("full_redir_load", 32'(pc_load), 32'(1));
    chk("full_redir_pc_in", 32'(pc_in), 32'(16'h0200));
    adv();
    redirect_valid = 1'b0;
    at_neg();
    chk("full_flushed", 32'(ir_valid), 32'(0));
    adv();
    ir_ready = 1'b1;
    expect_pops(2, 16'h0200, 30);

    // Redirect on the same cycle addr 7 is granted.
    do_reset(16'h0006);
    ir_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      at_neg();
      if (imem_req && imem_gnt && imem_addr == 16'h0007) begin found = 1'b1; break; end
      adv();
    end
    chk("grant_addr7", 32'(found), 32'(1));
    redirect_valid = 1'b1; redirect_addr = 16'h0300;
    #1; sample();
    chk("rg_pc_en", 32'(pc_enable), 32'(1));
    chk("rg_pc_load", 32'(pc_load), 32'(1));
    chk("rg_pc_in", 32'(pc_in), 32'(16'h0300));
    chk("rg_req_held", 32'(imem_req), 32'(1));
    adv();
    redirect_valid = 1'b0;
    chk("rg_pc_target", 32'(pc_reg), 32'(16'h0300));
    expect_pops(2, 16'h0300, 30);

    // PC wrap.
    do_reset(16'hFFFF);
    ir_ready = 1'b1;
    expect_pops(3, 16'hFFFF, 30);

    // Reset during WAIT, then a stray response.
    do_reset(16'h0040);
    auto_mem = 1'b0; imem_gnt = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      at_neg();
      if (imem_req && imem_gnt) found = 1'b1;
      adv();
      if (found) break;
    end
    chk("rst_first_grant", 32'(found), 32'(1));
    #2; reset = 1'b1; #1;
    sample();
    chk("rst_ctrl_zero", 32'({imem_req, pc_enable, pc_load, ir_valid}), 32'(0));
    chk("rst_pc_in", 32'(pc_in), 32'(0));
    chk("rst_imem_addr", 32'(imem_addr), 32'(0));
    chk("rst_ir_pc", 32'(ir_pc), 32'(0));
    chk("rst_ir_data", 32'(ir_data), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'hDEAD; pend = 1'b0;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk("stray_ignored", 32'(ir_valid), 32'(0));
      adv();
    end
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 5; c++) begin
      at_neg();
      if (imem_req && imem_gnt) begin
        found = 1'b1;
        chk("rst_restart_addr", 32'(imem_addr), 32'(16'h0041));
      end
      adv();
      if (found) break;
    end
    chk("rst_restart_grant", 32'(found), 32'(1));
    imem_rvalid = 1'b1; imem_rdata = 16'h1234;
    at_neg(); adv();
    imem_rvalid = 1'b0;
    at_neg();
    chk("rst_push_valid", 32'(ir_valid), 32'(1));
    chk("rst_push_pc", 32'(ir_pc), 32'(16'h0041));
    chk("rst_push_data", 32'(ir_data), 32'(16'h1234));
    adv();

    // Randomized run against the stream model.
    do_reset(16'($urandom));
    auto_mem = 1'b1; gnt_pct = 70; lat_min = 1; lat_max = 3;
    exp_pc = pc_reg; pops = 0;
    rand_mode = 1'b1; chk_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      at_neg();
      adv();
    end
    rand_mode = 1'b0; chk_en = 1'b0; redirect_valid = 1'b0;
    chk("rand_progress", 32'(pops >= 100), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
